// File: rtl/activity_stretch.sv
// Activity stretcher: shared ms prescaler, per-channel retriggerable hold counters, track register.
// Optional per-channel saturating event counters when ACT_STRETCH_EVCNT_EN is defined.
module activity_stretch #(
    parameter int unsigned CH       = 4,
    parameter int unsigned PRESCALE = 28000,
    parameter int unsigned HOLD     = 50
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CH-1:0]      strobe_in,
    input  logic [7:0]         track_in,
    input  logic               track_vld,
    output logic [CH-1:0]      act_out,
    output logic [7:0]         track_out,
    output logic               tick,
    input  logic               ev_clr,
    output logic [CH*16-1:0]   ev_cnt
);

    localparam int unsigned PRE_W = $clog2(PRESCALE);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
    localparam logic [7:0] HOLD_V = 8'(HOLD);

    logic [PRE_W-1:0]     pre_q, pre_d;
    logic                 tick_q, tick_d;
    logic [CH-1:0][7:0]   cnt_q, cnt_d;
    logic [CH-1:0]        act_q, act_d;
    logic [7:0]           track_q, track_d;

    // Prescaler; tick is registered so it is high while the counter sits at PRESCALE-1
    always_comb begin
        pre_d  = (pre_q == PRE_MAX) ? '0 : pre_q + PRE_W'(1);
        tick_d = (pre_d == PRE_MAX);
    end

    // Hold counters: strobe reload beats tick decrement
    always_comb begin
        cnt_d = cnt_q;
        act_d = '0;
        for (int i = 0; i < int'(CH); i++) begin
            if (strobe_in[i]) begin
                cnt_d[i] = HOLD_V;
            end else if (tick_q && (cnt_q[i] != 8'd0)) begin
                cnt_d[i] = cnt_q[i] - 8'd1;
            end
            act_d[i] = (cnt_d[i] != 8'd0);
        end
    end

    always_comb begin
        track_d = track_vld ? track_in : track_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            tick_q  <= 1'b0;
            cnt_q   <= '0;
            act_q   <= '0;
            track_q <= 8'h00;
        end else begin
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            track_q <= track_d;
        end
    end

    assign act_out   = act_q;
    assign track_out = track_q;
    assign tick      = tick_q;

`ifdef ACT_STRETCH_EVCNT_EN
    logic [CH-1:0][15:0] ev_q, ev_d;

    // Saturating event counters; clear wins over a coincident strobe
    always_comb begin
        ev_d = ev_q;
        if (ev_clr) begin
            ev_d = '0;
        end else begin
            for (int i = 0; i < int'(CH); i++) begin
                if (strobe_in[i] && (ev_q[i] != 16'hFFFF)) begin
                    ev_d[i] = ev_q[i] + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_q <= '0;
        end else begin
            ev_q <= ev_d;
        end
    end

    assign ev_cnt = ev_q;
`else
    logic ev_clr_unused;
    assign ev_clr_unused = ev_clr;
    assign ev_cnt        = '0;
`endif

endmodule

// File: tb/tb_activity_stretch.sv
// Directed self-checking bench for activity_stretch with PRESCALE=4, HOLD=3.
module tb_activity_stretch;

    localparam int unsigned CH       = 4;
    localparam int unsigned PRESCALE = 4;
    localparam int unsigned HOLD     = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CH-1:0]    strobe_in;
    logic [7:0]       track_in;
    logic             track_vld;
    logic [CH-1:0]    act_out;
    logic [7:0]       track_out;
    logic             tick;
    logic             ev_clr;
    logic [CH*16-1:0] ev_cnt;

    int checks = 0;
    int errors = 0;

    activity_stretch #(
        .CH       (CH),
        .PRESCALE (PRESCALE),
        .HOLD     (HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strobe_in (strobe_in),
        .track_in  (track_in),
        .track_vld (track_vld),
        .act_out   (act_out),
        .track_out (track_out),
        .tick      (tick),
        .ev_clr    (ev_clr),
        .ev_cnt    (ev_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Holds reset for a few cycles, checks reset values, releases at a negedge (cycle 0 follows)
    task automatic do_reset();
        rst_n     = 1'b0;
        strobe_in = '0;
        track_in  = 8'h00;
        track_vld = 1'b0;
        ev_clr    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst act",   64'(act_out),   64'h0);
        check("rst tick",  64'(tick),      64'h0);
        check("rst track", 64'(track_out), 64'h0);
        check("rst ev",    ev_cnt,         64'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0]  exp_act;
        logic [63:0] exp_ev;

        // Stretch, retrigger, strobe-on-tick, track capture
        do_reset();
        for (int cyc = 0; cyc < 28; cyc++) begin
            if (cyc > 0) @(negedge clk);
            strobe_in = '0;
            track_vld = 1'b0;
            if (cyc == 1)  strobe_in = 4'b0111;
            if (cyc == 9)  strobe_in[1] = 1'b1;
            if (cyc == 11) strobe_in[2] = 1'b1;
            if (cyc == 3) begin
                track_in  = 8'h4F;
                track_vld = 1'b1;
            end
            if (cyc == 5) track_in = 8'h12;

            exp_act = {1'b0, (cyc >= 2 && cyc <= 23), (cyc >= 2 && cyc <= 19), (cyc >= 2 && cyc <= 11)};
            check($sformatf("A tick c%0d", cyc),  64'(tick), 64'(cyc % 4 == 3));
            check($sformatf("A act c%0d", cyc),   64'(act_out), 64'(exp_act));
            check($sformatf("A track c%0d", cyc), 64'(track_out), (cyc >= 4) ? 64'h4F : 64'h00);
`ifdef ACT_STRETCH_EVCNT_EN
            exp_ev = {16'd0,
                      16'(cyc >= 2) + 16'(cyc >= 12),
                      16'(cyc >= 2) + 16'(cyc >= 10),
                      16'(cyc >= 2)};
`else
            exp_ev = 64'h0;
`endif
            check($sformatf("A ev c%0d", cyc), ev_cnt, exp_ev);
        end

        // All channels together, then asynchronous reset mid-hold while tick is high
        do_reset();
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc > 0) @(negedge clk);
            strobe_in = (cyc == 1) ? 4'hF : 4'h0;
            track_vld = (cyc == 2);
            track_in  = 8'hA5;
            check($sformatf("B tick c%0d", cyc),  64'(tick), 64'(cyc % 4 == 3));
            check($sformatf("B act c%0d", cyc),   64'(act_out), (cyc >= 2) ? 64'hF : 64'h0);
            check($sformatf("B track c%0d", cyc), 64'(track_out), (cyc >= 3) ? 64'hA5 : 64'h00);
        end
        rst_n     = 1'b0;
        track_vld = 1'b0;
        strobe_in = '0;
        #1;
        check("B async act",   64'(act_out),   64'h0);
        check("B async tick",  64'(tick),      64'h0);
        check("B async track", 64'(track_out), 64'h0);
        check("B async ev",    ev_cnt,         64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 9; cyc++) begin
            if (cyc > 0) @(negedge clk);
            check($sformatf("B post tick c%0d", cyc),  64'(tick), 64'(cyc % 4 == 3));
            check($sformatf("B post act c%0d", cyc),   64'(act_out), 64'h0);
            check($sformatf("B post track c%0d", cyc), 64'(track_out), 64'h0);
        end

        // Event counters
        do_reset();
`ifdef ACT_STRETCH_EVCNT_EN
        strobe_in = 4'b1000;
        for (int cyc = 1; cyc < 70000; cyc++) begin
            @(negedge clk);
            if (cyc == 5) check("C ev count 5", ev_cnt, {16'd5, 48'd0});
        end
        @(negedge clk);
        check("C ev saturate", ev_cnt, {16'hFFFF, 48'd0});
        ev_clr = 1'b1;
        @(negedge clk);
        check("C ev clear wins", ev_cnt, 64'h0);
        ev_clr = 1'b0;
        @(negedge clk);
        strobe_in = '0;
        check("C ev after clear", ev_cnt, {16'd1, 48'd0});
`else
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cyc > 0) @(negedge clk);
            strobe_in = 4'hF;
            ev_clr    = cyc[0];
            check($sformatf("C ev off c%0d", cyc), ev_cnt, 64'h0);
        end
        strobe_in = '0;
        ev_clr    = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
